// File: rtl/rca110_mem_arb_if.sv
// rca110_mem_arb_if: bundles the CPU port, the DMA port and the mm_* memory
// bus of the RCA 110 memory arbiter. The arbiter connects through the slave
// modport. The CPU, the I/O channel and the memory connect through the master
// modport.
interface rca110_mem_arb_if #(
  parameter int AW = 12,
  parameter int DW = 24
);
  // CPU requester
  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_adr;
  logic [DW-1:0] c_odat;
  logic          c_ack;
  logic [DW-1:0] c_idat;

  // DMA requester
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_adr;
  logic [DW-1:0] d_odat;
  logic          d_ack;
  logic [DW-1:0] d_idat;

  // Current owner, one-hot: [0]=CPU, [1]=DMA
  logic [1:0]    o_gnt;

  // Main memory bus
  logic [AW-1:0] mm_adr;
  logic          mm_we;
  logic [DW-1:0] mm_odat;
  logic [DW-1:0] mm_idat;

  modport slave (
    input  c_req, c_we, c_adr, c_odat,
    output c_ack, c_idat,
    input  d_req, d_we, d_adr, d_odat,
    output d_ack, d_idat,
    output o_gnt,
    output mm_adr, mm_we, mm_odat,
    input  mm_idat
  );

  modport master (
    output c_req, c_we, c_adr, c_odat,
    input  c_ack, c_idat,
    output d_req, d_we, d_adr, d_odat,
    input  d_ack, d_idat,
    input  o_gnt,
    input  mm_adr, mm_we, mm_odat,
    output mm_idat
  );
endinterface

// File: rtl/rca110_mem_arb.sv
// rca110_mem_arb: shares the single-port RCA 110 main memory (registered read)
// between the CPU and the I/O data channel. Each transaction takes three
// states: IDLE (grant), ACCESS (address cycle) and RESP (read data capture,
// then ack).
// Optional build macro RCA110_ARB_DMA_PRIO_EN: when it is defined, an eligible
// DMA request always beats the CPU. When it is not defined, simultaneous
// requests are resolved round-robin.
module rca110_mem_arb #(
  parameter int AW = 12,
  parameter int DW = 24
) (
  input  logic            i_clk,
  input  logic            i_rst,
  rca110_mem_arb_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t        state, state_d;
  logic          c_elig, d_elig;
  logic          grant_c, grant_d;

  logic [AW-1:0] mm_adr;
  logic          mm_we;
  logic [DW-1:0] mm_odat;
  logic          xfer_we;   // direction of the transaction in flight
  logic [1:0]    gnt;
  logic          c_ack, d_ack;
  logic [DW-1:0] c_idat, d_idat;
`ifndef RCA110_ARB_DMA_PRIO_EN
  logic          last_dma;  // 1: the most recent grant went to the DMA port
`endif

  assign bus.mm_adr  = mm_adr;
  assign bus.mm_we   = mm_we;
  assign bus.mm_odat = mm_odat;
  assign bus.o_gnt   = gnt;
  assign bus.c_ack   = c_ack;
  assign bus.d_ack   = d_ack;
  assign bus.c_idat  = c_idat;
  assign bus.d_idat  = d_idat;

  // State register. The async reset aborts any transaction in flight.
  // NOTE: registers are updated only with non-blocking assignments, so every
  // always_ff block reads the values from before the edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_d;
  end

  // Next state and the grant decision.
  // A requester whose ack is high in this cycle has not yet seen its ack, so
  // it is held off and cannot be granted again.
  // NOTE: every signal gets a default value first, so no path leaves a signal
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state;
    grant_c = 1'b0;
    grant_d = 1'b0;
    c_elig  = bus.c_req && !c_ack;
    d_elig  = bus.d_req && !d_ack;
    case (state)
      S_IDLE: begin
`ifdef RCA110_ARB_DMA_PRIO_EN
        grant_d = d_elig;
        grant_c = c_elig && !d_elig;
`else
        if (c_elig && d_elig) begin
          grant_c = last_dma;
          grant_d = !last_dma;
        end else begin
          grant_c = c_elig;
          grant_d = d_elig;
        end
`endif
        if (grant_c || grant_d) state_d = S_ACCESS;
      end
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Memory bus, grant, acks and returned read data.
  // NOTE: every datapath register, including the read-data holding registers,
  // has a reset value, so all outputs read 0 while reset is asserted.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mm_adr   <= '0;
      mm_we    <= 1'b0;
      mm_odat  <= '0;
      xfer_we  <= 1'b0;
      gnt      <= 2'b00;
      c_ack    <= 1'b0;
      d_ack    <= 1'b0;
      c_idat   <= '0;
      d_idat   <= '0;
`ifndef RCA110_ARB_DMA_PRIO_EN
      last_dma <= 1'b1;
`endif
    end else begin
      c_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_c) begin
            mm_adr  <= bus.c_adr;
            mm_we   <= bus.c_we;
            mm_odat <= bus.c_odat;
            xfer_we <= bus.c_we;
            gnt     <= 2'b01;
          end else if (grant_d) begin
            mm_adr  <= bus.d_adr;
            mm_we   <= bus.d_we;
            mm_odat <= bus.d_odat;
            xfer_we <= bus.d_we;
            gnt     <= 2'b10;
          end
        end
        S_ACCESS: begin
          // The memory commits the write at this edge. Dropping mm_we here
          // keeps the write strobe to exactly one cycle.
          mm_we <= 1'b0;
        end
        S_RESP: begin
          if (gnt[1]) begin
            d_ack <= 1'b1;
            if (!xfer_we) d_idat <= bus.mm_idat;
          end else begin
            c_ack <= 1'b1;
            if (!xfer_we) c_idat <= bus.mm_idat;
          end
          mm_we <= 1'b0;
          gnt   <= 2'b00;
`ifndef RCA110_ARB_DMA_PRIO_EN
          last_dma <= gnt[1];
`endif
        end
        default: begin
          mm_we <= 1'b0;
          gnt   <= 2'b00;
        end
      endcase
    end
  end

endmodule
